// File: rtl/cpu_sequencer.sv
// PIC10-style instruction sequencer: explicit FSM driving all datapath strobes.
// Optional SLEEP state is enabled by defining CPU_SLEEP_EN.
module cpu_sequencer #(
  parameter int NUM_PORTS   = 3,
  parameter int STACK_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          instr,
  input  logic [4:0]           reg_address,
  input  logic                 zero_result,
  input  logic                 mem_ready,
  input  logic                 wake,
  output logic                 load_ir,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic [1:0]           pc_mux_sel,
  output logic                 push,
  output logic                 pop,
  output logic                 store_w,
  output logic                 load_status,
  output logic                 load_fsr,
  output logic                 load_ram,
  output logic [NUM_PORTS-1:0] load_gpio,
  output logic [NUM_PORTS-1:0] load_tris,
  output logic                 reg_address_mux_sel,
  output logic                 alu_in_sel,
  output logic                 stack_overflow,
  output logic                 stack_underflow,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_EXEC   = 3'd1,
    S_SKIP   = 3'd2,
    S_REFILL = 3'd3,
    S_SLEEP  = 3'd4
  } state_t;

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  state_t         state_q, state_d;
  logic [SPW-1:0] sp_q;
  logic           ovf_q, unf_q;

  logic is_regop, is_bitset, is_decfsz, is_incfsz, is_btfsc, is_btfss;
  logic is_retlw, is_call, is_goto, is_lit, is_tris_grp;
  logic fwrite, wsel, skip_cond, pcl_wr, redirect;

  assign is_regop    = (instr[11:10] == 2'b00) && (instr[9:5] != 5'd0);
  assign is_bitset   = (instr[11:9] == 3'b010);
  assign is_decfsz   = (instr[11:6] == 6'b001011);
  assign is_incfsz   = (instr[11:6] == 6'b001111);
  assign is_btfsc    = (instr[11:8] == 4'b0110);
  assign is_btfss    = (instr[11:8] == 4'b0111);
  assign is_retlw    = (instr[11:8] == 4'b1000);
  assign is_call     = (instr[11:8] == 4'b1001);
  assign is_goto     = (instr[11:9] == 3'b101);
  assign is_lit      = (instr[11:10] == 2'b11);
  assign is_tris_grp = (instr[11:3] == 9'd0);

  assign fwrite    = (is_regop && instr[5]) || is_bitset;
  assign wsel      = is_regop && !instr[5];
  assign skip_cond = ((is_decfsz || is_incfsz || is_btfsc) && zero_result) ||
                     (is_btfss && !zero_result);
  assign pcl_wr    = fwrite && (reg_address == 5'd2);
  // Any PC redirect costs a refill cycle and overrides a pending skip.
  assign redirect  = pcl_wr || is_goto || is_call || is_retlw;

`ifdef CPU_SLEEP_EN
  logic is_sleep;
  assign is_sleep = (instr == 12'h003);
`else
  logic unused_wake;
  assign unused_wake = wake;
`endif

  always_comb begin
    state_d     = state_q;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    pc_mux_sel  = 2'd0;
    push        = 1'b0;
    pop         = 1'b0;
    store_w     = 1'b0;
    load_status = 1'b0;
    load_fsr    = 1'b0;
    load_ram    = 1'b0;
    load_gpio   = '0;
    load_tris   = '0;
    if (!rst && mem_ready) begin
      case (state_q)
        S_INIT, S_SKIP, S_REFILL: begin
          load_ir = 1'b1;
          inc_pc  = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          load_ir = !redirect;
          inc_pc  = !redirect;
          store_w = is_lit || wsel || is_retlw;
          if (fwrite) begin
            load_status = (reg_address == 5'd3);
            load_fsr    = (reg_address == 5'd4);
            load_ram    = (reg_address >= 5'd8);
            for (int p = 0; p < NUM_PORTS; p++)
              load_gpio[p] = (reg_address == 5'(5 + p));
          end
          if (is_tris_grp)
            for (int p = 0; p < NUM_PORTS; p++)
              load_tris[p] = (instr[2:0] == 3'(5 + p));
          if (pcl_wr || is_call) pc_mux_sel = 2'd1;
          if (is_goto)           pc_mux_sel = 2'd2;
          load_pc = redirect;
          push    = is_call;
          pop     = is_retlw;
          if (redirect)       state_d = S_REFILL;
          else if (skip_cond) state_d = S_SKIP;
          else                state_d = S_EXEC;
`ifdef CPU_SLEEP_EN
          if (is_sleep) begin
            load_ir = 1'b0;
            inc_pc  = 1'b0;
            state_d = S_SLEEP;
          end
`endif
        end
`ifdef CPU_SLEEP_EN
        S_SLEEP: begin
          if (wake) begin
            load_ir = 1'b1;
            inc_pc  = 1'b1;
            state_d = S_EXEC;
          end
        end
`endif
        default: state_d = S_INIT;
      endcase
    end
  end

  // Overflowing push / underflowing pop still reach the stack; sp saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        if (sp_q == SPW'(STACK_DEPTH)) ovf_q <= 1'b1;
        else                           sp_q  <= sp_q + SPW'(1);
      end
      if (pop) begin
        if (sp_q == '0) unf_q <= 1'b1;
        else            sp_q  <= sp_q - SPW'(1);
      end
    end
  end

  assign reg_address_mux_sel = (instr[4:0] == 5'd0);
  assign alu_in_sel          = (instr[4:0] > 5'd7);
  assign stack_overflow      = ovf_q;
  assign stack_underflow     = unf_q;
  assign state               = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven cycle vectors for cpu_sequencer (NUM_PORTS=2, STACK_DEPTH=2),
// plus hand sequences for reset-in-flight and the optional SLEEP state.
module tb_cpu_sequencer;

  localparam logic [14:0] IR = 15'h4000, INC = 15'h2000, LPC = 15'h1000;
  localparam logic [14:0] SEL1 = 15'h0400, SEL2 = 15'h0800;
  localparam logic [14:0] PUSH = 15'h0200, POP = 15'h0100, W = 15'h0080;
  localparam logic [14:0] ST = 15'h0040, FSR = 15'h0020, RAM = 15'h0010;
  localparam logic [14:0] G0 = 15'h0004, G1 = 15'h0008, T0 = 15'h0001, T1 = 15'h0002;
  localparam logic [14:0] FE = IR | INC, NONE = 15'h0000;
  localparam logic [2:0] INIT = 3'd0, EXEC = 3'd1, SKIP = 3'd2, REFILL = 3'd3, SLP = 3'd4;

  logic clk, rst, zero_result, mem_ready, wake;
  logic [11:0] instr;
  logic [4:0] reg_address;
  logic load_ir, inc_pc, load_pc, push, pop, store_w, load_status, load_fsr, load_ram;
  logic [1:0] pc_mux_sel, load_gpio, load_tris;
  logic reg_address_mux_sel, alu_in_sel, stack_overflow, stack_underflow;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass = 0;

  cpu_sequencer #(.NUM_PORTS(2), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .instr(instr), .reg_address(reg_address),
    .zero_result(zero_result), .mem_ready(mem_ready), .wake(wake),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .pc_mux_sel(pc_mux_sel),
    .push(push), .pop(pop), .store_w(store_w), .load_status(load_status),
    .load_fsr(load_fsr), .load_ram(load_ram), .load_gpio(load_gpio),
    .load_tris(load_tris), .reg_address_mux_sel(reg_address_mux_sel),
    .alu_in_sel(alu_in_sel), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] i;
    logic [4:0]  a;
    logic        z;
    logic        rdy;
    logic [14:0] exp;
    logic [2:0]  st;
    logic [1:0]  fl;
  } row_t;

  function automatic row_t R(logic [11:0] i, logic [4:0] a, logic z, logic rdy,
                             logic [14:0] e, logic [2:0] s, logic [1:0] f);
    row_t r;
    r.i = i; r.a = a; r.z = z; r.rdy = rdy; r.exp = e; r.st = s; r.fl = f;
    return r;
  endfunction

  function automatic logic [14:0] strobes();
    return {load_ir, inc_pc, load_pc, pc_mux_sel, push, pop, store_w,
            load_status, load_fsr, load_ram, load_gpio, load_tris};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Drive one cycle's inputs, compare before the edge, then advance.
  task automatic apply(input row_t r, input string name);
    instr = r.i; reg_address = r.a; zero_result = r.z; mem_ready = r.rdy;
    #1;
    check(name, {12'd0, state, stack_overflow, stack_underflow, strobes()},
          {12'd0, r.st, r.fl, r.exp});
    @(posedge clk); #1;
  endtask

  row_t tbl[$];

  initial begin
    rst = 1'b1; instr = 12'hC55; reg_address = 5'd0; zero_result = 1'b0;
    mem_ready = 1'b1; wake = 1'b0;

    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE,             INIT,   2'b00));
    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE | W,         EXEC,   2'b00));
    tbl.push_back(R(12'hA25, 5'd0,  0, 1, LPC | SEL2,     EXEC,   2'b00));
    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE,             REFILL, 2'b00));
    tbl.push_back(R(12'h940, 5'd0,  0, 1, LPC|SEL1|PUSH,  EXEC,   2'b00));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b00));
    tbl.push_back(R(12'h940, 5'd0,  0, 1, LPC|SEL1|PUSH,  EXEC,   2'b00));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b00));
    tbl.push_back(R(12'h940, 5'd0,  0, 1, LPC|SEL1|PUSH,  EXEC,   2'b00));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b10));
    tbl.push_back(R(12'h812, 5'd0,  0, 1, LPC | POP | W,  EXEC,   2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b10));
    tbl.push_back(R(12'h2F0, 5'd16, 1, 1, FE | RAM,       EXEC,   2'b10));
    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE,             SKIP,   2'b10));
    tbl.push_back(R(12'h2F0, 5'd16, 0, 1, FE | RAM,       EXEC,   2'b10));
    tbl.push_back(R(12'h026, 5'd6,  0, 1, FE | G1,        EXEC,   2'b10));
    tbl.push_back(R(12'h027, 5'd7,  0, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'h007, 5'd7,  0, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'h006, 5'd6,  0, 1, FE | T1,        EXEC,   2'b10));
    tbl.push_back(R(12'h005, 5'd5,  0, 1, FE | T0,        EXEC,   2'b10));
    tbl.push_back(R(12'hC55, 5'd0,  0, 0, NONE,           EXEC,   2'b10));
    tbl.push_back(R(12'hA25, 5'd0,  0, 0, NONE,           EXEC,   2'b10));
    tbl.push_back(R(12'h1C3, 5'd3,  0, 1, FE | W,         EXEC,   2'b10));
    tbl.push_back(R(12'h1E3, 5'd3,  0, 1, FE | ST,        EXEC,   2'b10));
    tbl.push_back(R(12'h024, 5'd4,  0, 1, FE | FSR,       EXEC,   2'b10));
    tbl.push_back(R(12'h020, 5'd5,  0, 1, FE | G0,        EXEC,   2'b10));
    tbl.push_back(R(12'h021, 5'd1,  0, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'h503, 5'd3,  0, 1, FE | ST,        EXEC,   2'b10));
    tbl.push_back(R(12'h703, 5'd3,  0, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE,             SKIP,   2'b10));
    tbl.push_back(R(12'h703, 5'd3,  1, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'h603, 5'd3,  1, 1, FE,             EXEC,   2'b10));
    tbl.push_back(R(12'hC55, 5'd0,  0, 0, NONE,           SKIP,   2'b10));
    tbl.push_back(R(12'hC55, 5'd0,  0, 1, FE,             SKIP,   2'b10));
    tbl.push_back(R(12'h3E2, 5'd2,  1, 1, LPC | SEL1,     EXEC,   2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b10));
    tbl.push_back(R(12'h022, 5'd2,  0, 1, LPC | SEL1,     EXEC,   2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 0, NONE,           REFILL, 2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b10));
    tbl.push_back(R(12'h812, 5'd0,  0, 1, LPC | POP | W,  EXEC,   2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b10));
    tbl.push_back(R(12'h812, 5'd0,  0, 1, LPC | POP | W,  EXEC,   2'b10));
    tbl.push_back(R(12'h000, 5'd0,  0, 1, FE,             REFILL, 2'b11));
    tbl.push_back(R(12'h002, 5'd0,  0, 1, FE,             EXEC,   2'b11));
    tbl.push_back(R(12'h004, 5'd0,  0, 1, FE,             EXEC,   2'b11));

    // Reset held: INIT, no strobes even though mem_ready=1, flags clear.
    @(posedge clk); #1;
    check("rst_state", {29'd0, state}, {29'd0, INIT});
    check("rst_strobes", {17'd0, strobes()}, {17'd0, NONE});
    check("rst_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
    @(posedge clk); #1;
    check("rst_strobes2", {17'd0, strobes()}, {17'd0, NONE});
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++)
      apply(tbl[k], $sformatf("row%0d", k));

    // Reset mid-instruction while in REFILL abandons it.
    apply(R(12'hA25, 5'd0, 0, 1, LPC | SEL2, EXEC, 2'b11), "goto_pre_rst");
    rst = 1'b1; #1;
    check("rst_refill_strobes", {17'd0, strobes()}, {17'd0, NONE});
    @(posedge clk); #1;
    check("rst_refill_state", {29'd0, state}, {29'd0, INIT});
    check("rst_clears_flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
    rst = 1'b0;
    apply(R(12'hC55, 5'd0, 0, 1, FE, INIT, 2'b00), "init_after_rst");

`ifdef CPU_SLEEP_EN
    apply(R(12'h003, 5'd0, 0, 1, NONE, EXEC, 2'b00), "sleep_enter");
    for (int k = 0; k < 10; k++)
      apply(R(12'h000, 5'd0, 0, 1, NONE, SLP, 2'b00), $sformatf("sleep_hold%0d", k));
    wake = 1'b1;
    apply(R(12'hC55, 5'd0, 0, 1, FE, SLP, 2'b00), "sleep_wake");
    apply(R(12'h003, 5'd0, 0, 1, NONE, EXEC, 2'b00), "sleep_with_wake");
    apply(R(12'hC55, 5'd0, 0, 1, FE, SLP, 2'b00), "sleep_one_cycle");
    wake = 1'b0;
    apply(R(12'h003, 5'd0, 0, 1, NONE, EXEC, 2'b00), "sleep_again");
    apply(R(12'h000, 5'd0, 0, 0, NONE, SLP, 2'b00), "sleep_not_ready");
    rst = 1'b1; #1;
    check("rst_sleep_strobes", {17'd0, strobes()}, {17'd0, NONE});
    @(posedge clk); #1;
    check("rst_sleep_state", {29'd0, state}, {29'd0, INIT});
    rst = 1'b0;
`else
    apply(R(12'hC55, 5'd0, 0, 1, FE | W, EXEC, 2'b00), "movlw_after_rst");
    wake = 1'b1;
    apply(R(12'h003, 5'd0, 0, 1, FE, EXEC, 2'b00), "sleep_is_nop_wake");
    wake = 1'b0;
    apply(R(12'h003, 5'd0, 0, 1, FE, EXEC, 2'b00), "sleep_is_nop");
    apply(R(12'hC55, 5'd0, 0, 1, FE | W, EXEC, 2'b00), "after_sleep_nop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised instruction sequencer for the PIC10-compatible CPU core. It replaces the flag-based single-cycle controller with an explicit state machine and drives every datapath strobe: IR load, PC increment/load, stack push/pop, W, STATUS, FSR, RAM, GPIO and TRIS writes. Over the previous controller it adds:
- a configurable GPIO/TRIS port count and stack depth;
- a program-memory ready handshake;
- internal skip handling;
- single-cycle RETLW;
- sticky stack-fault flags.

## Interface
- NUM_PORTS, 3, GPIO/TRIS ports, 1..3. GPIOn sits at file address 5+n; TRIS f targets port f-5.
- STACK_DEPTH, 2, hardware return-stack entries, 1..8.

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- instr  in  12  current IR contents; decoded with the opcode macros in definition.vh
- reg_address  in  5  effective file address after FSR indirection
- zero_result  in  1  ALU zero flag for the current instruction
- mem_ready  in  1  program memory word valid this cycle
- wake  in  1  wake request; used only with CPU_SLEEP_EN
- load_ir, inc_pc, load_pc  out  1 each  IR/PC strobes
- pc_mux_sel  out  2  PC source: 0 = stack top, 1 = ALU result, 2 = IR literal
- push, pop  out  1 each  return-stack strobes
- store_w, load_status, load_fsr, load_ram  out  1 each  result write strobes
- load_gpio, load_tris  out  NUM_PORTS each  per-port write strobes
- reg_address_mux_sel  out  1  1 when instr[4:0]==0 (indirect addressing)
- alu_in_sel  out  1  1 when instr[4:0]>7 (RAM source)
- stack_overflow, stack_underflow  out  1 each  sticky fault flags
- state  out  3  current FSM state, for debug

## Operation
- Strobes are combinational from state, instr, reg_address, zero_result and mem_ready. They take effect at the next posedge.
- When mem_ready=0, every strobe is 0 and the state is held. A whole instruction therefore waits.

States:
- INIT
  - Asserts load_ir and inc_pc, then goes to EXEC.
- EXEC
  - Asserts load_ir and inc_pc, plus the instruction's strobes.
  - File-write destination, applied when d=1 for the register ops and always for BCF/BSF:
    - address 0 or 1: write discarded;
    - address 2: load_pc with sel=1, then go to REFILL (suppresses that cycle's load_ir and inc_pc);
    - address 3: load_status;
    - address 4: load_fsr;
    - address 5..4+NUM_PORTS: load_gpio[addr-5];
    - other addresses 5..7: write discarded;
    - address 8 and above: load_ram.
  - If d=0, assert store_w instead of the file write.
  - Literal ops (ANDLW, IORLW, XORLW, MOVLW) assert store_w.
  - TRIS f with f in 5..4+NUM_PORTS asserts load_tris[f-5]. Any other f is a NOP.
  - Skip conditions:
    - DECFSZ, INCFSZ, BTFSC skip when zero_result=1;
    - BTFSS skips when zero_result=0.
    - On a skip, perform the writes, then go to SKIP.
    - A PCL write takes precedence over a skip (go to REFILL).
  - GOTO asserts load_pc with sel=2, then goes to REFILL.
  - CALL asserts push and load_pc with sel=1, then goes to REFILL.
  - RETLW asserts pop, load_pc with sel=0 and store_w in the same cycle, then goes to REFILL. The stack presents its top entry before the pop takes effect.
  - NOP, OPTION, CLRWDT: only load_ir and inc_pc.
- SKIP
  - Asserts load_ir and inc_pc. The fetched instruction is discarded, with no execute strobes.
  - Then goes to EXEC.
- REFILL
  - Asserts load_ir and inc_pc, then goes to EXEC.
- SLEEP
  - Exists only with CPU_SLEEP_EN (see Configuration).

Stack accounting:
- An internal counter sp runs 0..STACK_DEPTH.
- Push at sp==STACK_DEPTH sets stack_overflow. The push is still issued (wrap) and sp holds.
- Pop at sp==0 sets stack_underflow. The pop is still issued and sp holds.

## Timing
- During rst and on the cycle it deasserts, the state is INIT, all strobes are 0, sp=0 and both flags are cleared.
- The flags are cleared only by rst.
- Reset mid-instruction, including in SKIP, REFILL or SLEEP, abandons it: state returns to INIT with no partial strobes.
- Cycle counts (mem_ready held at 1):
  - ALU and literal ops: 1 cycle;
  - GOTO, CALL, RETLW, PCL write: 2 cycles;
  - taken skip: 2 cycles.
- The first load_ir occurs on the first posedge after rst falls with mem_ready=1.
- Each cycle with mem_ready=0 adds exactly one cycle to any state.

## Configuration
- CPU_SLEEP_EN defined:
  - SLEEP (12'h003) moves EXEC to SLEEP, with all strobes 0.
  - SLEEP holds until wake=1.
  - wake=1 causes load_ir and inc_pc, then a transition to EXEC.
  - With wake=1 during the SLEEP instruction itself, the block still enters SLEEP for one cycle.
- CPU_SLEEP_EN undefined:
  - SLEEP decodes as a NOP.
  - wake is ignored.
  - The SLEEP state is unreachable.

## Test plan
- Reset with instr=12'hC55 (MOVLW 0x55), mem_ready=1 -> INIT load_ir=1; next cycle EXEC store_w=1, load_ir=1, inc_pc=1.
- GOTO 12'hA25 -> load_pc=1 with pc_mux_sel=2 and no load_ir; next cycle REFILL load_ir=1; then EXEC.
- STACK_DEPTH=2: three CALLs 12'h940 with no return -> third asserts push=1 and stack_overflow=1; RETLW 12'h812 then pop=1, load_pc=1 with sel=0, store_w=1 in one cycle.
- DECFSZ 12'h2F0 with zero_result=1 -> load_ram=1, SKIP cycle with only load_ir and inc_pc; with zero_result=0 -> no SKIP.
- NUM_PORTS=2: MOVWF 12'h026 -> load_gpio=2'b10; MOVWF 12'h027 -> no strobe; TRIS 12'h007 -> NOP; any cycle with mem_ready=0 -> all strobes 0 and state held.
- CPU_SLEEP_EN: SLEEP, hold wake=0 for 10 cycles -> all strobes 0; wake=1 -> load_ir=1; rst asserted in SLEEP -> INIT.
